// File: rtl/wdt_kick_gen.sv
// Periodic watchdog kick generator gated by a heartbeat window.
// Define WDT_KICK_GEN_STATS_EN to build the reset/miss statistics counters.
module wdt_kick_gen #(
  parameter int CNT_W    = 32,
  parameter int RST_HOLD = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic             alive_i,
  input  logic             sys_rst_i,
  output logic             kick_o,
  output logic             missed_o,
  output logic [7:0]       rst_cnt_o,
  output logic [7:0]       miss_cnt_o
);

  localparam int HW = $clog2(RST_HOLD + 2);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    KICK,
    BLOCKED
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] per_eff;
  logic [HW-1:0]    hold_q, hold_d;
  logic             alive_q, alive_d;
  logic             miss_d, kick_d;
  logic             win_end, hold_done, beat;

  assign per_eff = (period_i < CNT_W'(2)) ?
                   CNT_W'(2) : period_i;
  assign win_end = (cnt_q == per_q - 1'b1);
  assign beat    = alive_q | alive_i;
  assign hold_done = !sys_rst_i &&
                     (hold_q + 1'b1 == HW'(RST_HOLD));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    alive_d = alive_q;
    hold_d  = '0;
    miss_d  = 1'b0;
    if (sys_rst_i) begin
      // Watchdog reset wins over any pending kick.
      state_d = BLOCKED;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (en_i) begin
            state_d = COUNT;
            cnt_d   = '0;
            per_d   = per_eff;
            alive_d = alive_i;
          end
        end
        COUNT: begin
          if (!en_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            alive_d = 1'b0;
          end else if (!win_end) begin
            cnt_d   = cnt_q + 1'b1;
            alive_d = beat;
          end else if (beat) begin
            state_d = KICK;
            alive_d = beat;
          end else begin
            miss_d  = 1'b1;
            cnt_d   = '0;
            alive_d = 1'b0;
          end
        end
        KICK: begin
          cnt_d   = CNT_W'(1);
          alive_d = alive_i;
          state_d = en_i ? COUNT : IDLE;
        end
        BLOCKED: begin
          cnt_d  = '0;
          hold_d = hold_q + 1'b1;
          if (hold_done) begin
            hold_d  = '0;
            alive_d = 1'b0;
            if (en_i) begin
              state_d = COUNT;
              per_d   = per_eff;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    kick_d = (state_d == KICK);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      per_q    <= CNT_W'(2);
      hold_q   <= '0;
      alive_q  <= 1'b0;
      kick_o   <= 1'b0;
      missed_o <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      hold_q   <= hold_d;
      alive_q  <= alive_d;
      kick_o   <= kick_d;
      missed_o <= miss_d;
    end
  end

`ifdef WDT_KICK_GEN_STATS_EN
  logic       r1_q, r2_q;
  logic [7:0] rst_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r1_q       <= 1'b0;
      r2_q       <= 1'b0;
      rst_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      r1_q <= sys_rst_i;
      r2_q <= r1_q;
      if (r1_q && !r2_q && rst_cnt_q != 8'hff)
        rst_cnt_q <= rst_cnt_q + 8'd1;
      if (miss_d && miss_cnt_q != 8'hff)
        miss_cnt_q <= miss_cnt_q + 8'd1;
    end
  end

  assign rst_cnt_o  = rst_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  assign rst_cnt_o  = 8'd0;
  assign miss_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_wdt_kick_gen.sv
// Directed bench for wdt_kick_gen: per-cycle vector tables
// plus reset-pulse saturation and reset sequences.
module tb_wdt_kick_gen;

`ifdef WDT_KICK_GEN_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        en_i = 1'b0;
  logic [31:0] period_i = 32'd0;
  logic        alive_i = 1'b0;
  logic        sys_rst_i = 1'b0;
  logic        kick_o, missed_o;
  logic [7:0]  rst_cnt_o, miss_cnt_o;

  int checks = 0;
  int errors = 0;

  wdt_kick_gen #(.CNT_W(32), .RST_HOLD(4)) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .en_i(en_i),
    .period_i(period_i),
    .alive_i(alive_i),
    .sys_rst_i(sys_rst_i),
    .kick_o(kick_o),
    .missed_o(missed_o),
    .rst_cnt_o(rst_cnt_o),
    .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        en;
    logic [31:0] per;
    logic        alive;
    logic        srst;
    logic        kick;
    logic        miss;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic en, input int per,
                              input logic alive, input logic srst,
                              input logic kick, input logic miss);
    vec_t v;
    v.en = en; v.per = per; v.alive = alive;
    v.srst = srst; v.kick = kick; v.miss = miss;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic en, input int per,
                      input logic alive, input logic srst);
    en_i = en; period_i = per; alive_i = alive; sys_rst_i = srst;
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_tbl(input string nm);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].en, int'(tbl[i].per), tbl[i].alive, tbl[i].srst);
      chk($sformatf("%s[%0d] {kick,miss}", nm, i),
          int'({kick_o, missed_o}), int'({tbl[i].kick, tbl[i].miss}));
    end
    tbl.delete();
  endtask

  task automatic do_reset(input logic en, input int per,
                          input logic alive);
    rst_ni = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(en, per, alive, 1'b0);
      chk($sformatf("reset[%0d] outputs", i),
          int'({kick_o, missed_o, rst_cnt_o, miss_cnt_o}), 0);
    end
    rst_ni = 1'b1;
  endtask

  initial begin
    // Reset with enable high, then periodic kicks at P=10.
    do_reset(1'b1, 10, 1'b1);
    for (int k = 0; k <= 30; k++)
      add(1'b1, 10, 1'b1, 1'b0, (k > 0) && (k % 10 == 0), 1'b0);
    add(1'b0, 10, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b0, 10, 1'b1, 1'b0, 1'b0, 1'b0);
    run_tbl("periodic");

    // Two missed windows, heartbeat in the third.
    do_reset(1'b1, 8, 1'b0);
    for (int k = 0; k <= 24; k++)
      add(1'b1, 8, k == 20, 1'b0, k == 24, (k == 8) || (k == 16));
    run_tbl("missed");
    chk("miss_cnt after 2 misses", int'(miss_cnt_o), STATS ? 2 : 0);

    // Period 0 and 1 both act as 2; later period changes ignored.
    do_reset(1'b1, 0, 1'b1);
    for (int k = 0; k <= 6; k++)
      add(1'b1, 0, 1'b1, 1'b0, (k == 2) || (k == 4) || (k == 6), 1'b0);
    add(1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 9; k <= 14; k++)
      add(1'b1, 7, 1'b1, 1'b0, (k == 10) || (k == 12) || (k == 14), 1'b0);
    run_tbl("minper");

    // Watchdog reset for 5 cycles mid-window.
    do_reset(1'b1, 10, 1'b1);
    for (int k = 0; k <= 24; k++)
      add(1'b1, 10, 1'b1, (k >= 5) && (k <= 9), k == 23, 1'b0);
    run_tbl("blocked");
    chk("rst_cnt after one reset", int'(rst_cnt_o), STATS ? 1 : 0);

    // Reset arriving on the edge a kick is due.
    do_reset(1'b1, 4, 1'b1);
    for (int k = 0; k <= 12; k++)
      add(1'b1, 4, 1'b1, k == 4, k == 12, 1'b0);
    run_tbl("priority");
    chk("rst_cnt priority", int'(rst_cnt_o), STATS ? 1 : 0);

    // Saturation of the reset-edge counter.
    do_reset(1'b0, 4, 1'b0);
    for (int p = 0; p < 100; p++) begin
      step(1'b0, 4, 1'b0, 1'b1);
      step(1'b0, 4, 1'b0, 1'b0);
    end
    chk("rst_cnt after 100", int'(rst_cnt_o), STATS ? 100 : 0);
    for (int p = 0; p < 200; p++) begin
      step(1'b0, 4, 1'b0, 1'b1);
      step(1'b0, 4, 1'b0, 1'b0);
    end
    chk("rst_cnt saturated", int'(rst_cnt_o), STATS ? 255 : 0);
    chk("no kick during pulses", int'({kick_o, missed_o}), 0);

    // Reset clears the saturated counter.
    do_reset(1'b0, 4, 1'b0);
    chk("rst_cnt cleared", int'(rst_cnt_o), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/wdt_kick_gen.md
# wdt_kick_gen

Periodic kick generator that drives the `kick_i` input of the `watchdog` block and consumes its `sys_rst_o` output. It issues a one-cycle kick every `period_i` cycles, but only if a software/core heartbeat (`alive_i`) was seen in the elapsed window. A missing heartbeat suppresses the kick and lets the watchdog expire. It also backs off while the watchdog holds system reset.

## Interface
- `CNT_W`, default 32: width of the period counter and of `period_i`.
- `RST_HOLD`, default 4: number of consecutive cycles `sys_rst_i` must be low before leaving BLOCKED.
- `clk_i`  in  1  clock; single clock domain.
- `rst_ni`  in  1  reset; synchronous, active-low.
- `en_i`  in  1  enable; level-sensitive.
- `period_i`  in  CNT_W  kick period in cycles; latched on entry to COUNT.
- `alive_i`  in  1  heartbeat; any high cycle in a window qualifies that window.
- `sys_rst_i`  in  1  system reset from the watchdog (`sys_rst_o`).
- `kick_o`  out  1  kick pulse to the watchdog; exactly one cycle wide.
- `missed_o`  out  1  one-cycle pulse when a window closes without a heartbeat.
- `rst_cnt_o`  out  8  saturating count of `sys_rst_i` rising edges.
- `miss_cnt_o`  out  8  saturating count of `missed_o` pulses.

## Operation
- FSM states: IDLE, COUNT, KICK, BLOCKED. All outputs are registered.
- Reset (`rst_ni`=0 at a clock edge):
  - state becomes IDLE.
  - `kick_o`, `missed_o`, `rst_cnt_o`, `miss_cnt_o`, the counter and the `alive_seen` flag all become 0.
- Effective period `P` = max(`period_i`, 2). It is latched into `per_q` on every IDLE→COUNT or BLOCKED→COUNT transition; later changes to `period_i` are ignored until the next such transition.
- IDLE:
  - `en_i`=1 → COUNT; counter←0; `alive_seen`←`alive_i`.
- COUNT:
  - `alive_i`=1 sets `alive_seen`.
  - If counter ≠ P−1: counter increments.
  - If counter = P−1 and (`alive_seen` or `alive_i`) → KICK.
  - If counter = P−1 with no heartbeat → `missed_o` pulses, counter←0, `alive_seen`←0, stay in COUNT.
  - `en_i`=0 → IDLE; the current window is discarded.
- KICK:
  - `kick_o`=1 for this cycle only.
  - counter←1; `alive_seen`←`alive_i`, so a heartbeat in the KICK cycle counts toward the next window.
  - Next state is COUNT if `en_i`=1, else IDLE.
- BLOCKED:
  - `kick_o`=0, counter cleared.
  - A hold counter counts consecutive cycles with `sys_rst_i`=0 and clears whenever `sys_rst_i`=1.
  - When the hold counter reaches RST_HOLD: go to COUNT (latch P, counter←0, `alive_seen`←0) if `en_i`=1, else IDLE.
- `sys_rst_i`=1 in any state → BLOCKED next cycle. This has priority over all other transitions, including a pending KICK.
- Counters are 8 bits wide and saturate at 255; they never wrap.

## Timing
- `en_i` sampled high at edge t0, `alive_i` held high: `kick_o` is high in the cycle after edge t0+P, then every P cycles.
- Kick spacing is exactly P cycles while heartbeats continue. `missed_o` occurs at the same edges where a kick would have occurred.
- `sys_rst_i` rising at edge e:
  - state is BLOCKED after e; `rst_cnt_o` increments at e+1.
  - if `sys_rst_i` falls at edge f, COUNT is entered at edge f+RST_HOLD−1.
- `kick_o` and `missed_o` are never both high, and are never high in consecutive cycles.

## Configuration
- `WDT_KICK_GEN_STATS_EN` defined: `rst_cnt_o` and `miss_cnt_o` are implemented as described.
- `WDT_KICK_GEN_STATS_EN` not defined: both ports are tied to 0 and no counter registers are instantiated. `missed_o` and all FSM behaviour are unchanged.

## Test plan
- Reset check: assert `rst_ni`=0 for 2 cycles with `en_i`=1 → all outputs are 0 and no kick occurs during reset.
- Periodic kicks: `period_i`=10, `alive_i`=1, `en_i` rises at t0 → kicks after edges t0+10, t0+20, t0+30; `missed_o` stays 0.
- Missed heartbeat:
  - stimulus: `period_i`=8, `alive_i`=0 for 2 windows, then a single `alive_i` pulse in window 3.
  - response: `missed_o` pulses twice with no kick, then a kick at the end of window 3; `miss_cnt_o`=2.
- Minimum period: `period_i`=0, then 1 → each is treated as P=2; a kick every 2 cycles with `alive_i`=1.
- Watchdog reset mid-window:
  - stimulus: `sys_rst_i` high for 5 cycles while in COUNT, RST_HOLD=4.
  - response: no kick while blocked; `rst_cnt_o`=1; counting resumes 3 edges after `sys_rst_i` falls, and the first kick follows P cycles later.
- Priority and saturation: `sys_rst_i`=1 on the edge where a kick is due → no kick. Repeat 300 reset pulses → `rst_cnt_o`=255.
